// File: rtl/fmps_read_links_multi_if.sv
// fmps_read_links_multi_if: per-link FMPS status event bus from the link receivers
// Ports (per link k): statusValid[k] event strobe, statusCode[2k+:2] code (0 = success),
// statusEnabled[k] node-enabled flag, statusIndex[k*INDEX_WIDTH+:INDEX_WIDTH] node index.
// master = link receivers (drive), slave = readout tracker (sample).
interface fmps_read_links_multi_if #(
  parameter int NUM_LINKS = 2,
  parameter int INDEX_WIDTH = 5
);
  logic [NUM_LINKS-1:0] statusValid;
  logic [2*NUM_LINKS-1:0] statusCode;
  logic [NUM_LINKS-1:0] statusEnabled;
  logic [NUM_LINKS*INDEX_WIDTH-1:0] statusIndex;
  modport master (output statusValid, statusCode, statusEnabled, statusIndex);
  modport slave (input statusValid, statusCode, statusEnabled, statusIndex);
endinterface

// File: rtl/fmps_read_links_multi.sv
// fmps_read_links_multi: multi-link Fast MPS readout tracker (completion/timeout per FA cycle)
// Ports: sysClk/sysResetN clock and async active-low reset; FAstrobe starts an FA cycle;
// fmpsCount expected node count; linkInhibit per-link ignore mask (latched on FAstrobe);
// status per-link event bus; errorCountClear clears linkErrorCount;
// readoutActive/readoutValid/readTimeout/timeoutStrobe/fmpsEnabled readout status;
// fmpsBitmapAll/fmpsBitmapEnabled live bitmaps, *Snapshot copies taken at FAstrobe;
// readoutTime microsecond timer at end of readout; seqno completed-readout count;
// linkErrorCount 16-bit saturating count per link; readoutAddress -> readoutPresent/readoutLink lookup.
module fmps_read_links_multi #(
  parameter int NUM_LINKS = 2,
  parameter int INDEX_WIDTH = 5,
  parameter int SYSCLK_RATE = 100000000,
  parameter int READOUT_TIMER_WIDTH = 5,
  parameter int SEQNO_WIDTH = 3,
  localparam int LINK_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1,
  localparam int NODES = 1 << INDEX_WIDTH
) (
  input  logic sysClk,
  input  logic sysResetN,
  input  logic FAstrobe,
  input  logic [INDEX_WIDTH:0] fmpsCount,
  input  logic [NUM_LINKS-1:0] linkInhibit,
  fmps_read_links_multi_if.slave status,
  input  logic errorCountClear,
  output logic readoutActive,
  output logic readoutValid,
  output logic readTimeout,
  output logic timeoutStrobe,
  output logic fmpsEnabled,
  output logic [NODES-1:0] fmpsBitmapAll,
  output logic [NODES-1:0] fmpsBitmapEnabled,
  output logic [NODES-1:0] bitmapAllSnapshot,
  output logic [NODES-1:0] bitmapEnabledSnapshot,
  output logic [READOUT_TIMER_WIDTH-1:0] readoutTime,
  output logic [SEQNO_WIDTH-1:0] seqno,
  output logic [16*NUM_LINKS-1:0] linkErrorCount,
  input  logic [INDEX_WIDTH-1:0] readoutAddress,
  output logic readoutPresent,
  output logic [LINK_W-1:0] readoutLink
);
  localparam logic [31:0] HALF_LOAD = 32'(SYSCLK_RATE / 2000000 - 1);
  localparam logic [31:0] FULL_LOAD = 32'(SYSCLK_RATE / 1000000 - 1);
  logic [NUM_LINKS-1:0] inhibitLatched, accept;
  logic [INDEX_WIDTH:0] allCount, enCount, addAll, addEn;
  logic [NODES-1:0] newAll, newEn, freshAll, freshEn;
  logic [LINK_W-1:0] sourceTable [NODES];
  logic [LINK_W-1:0] winner [NODES];
  logic [READOUT_TIMER_WIDTH-1:0] timer;
  logic [31:0] divider;
  // Merge every link's event in one cycle; walking links downward lets the lowest link win ties.
  always_comb begin
    accept = '0;
    newAll = '0;
    newEn = '0;
    addAll = '0;
    addEn = '0;
    for (int i = 0; i < NODES; i++) winner[i] = '0;
    for (int k = NUM_LINKS - 1; k >= 0; k--) begin
      accept[k] = status.statusValid[k] && status.statusCode[2*k +: 2] == 2'd0 &&
                  !inhibitLatched[k] && readoutActive && !FAstrobe;
      if (accept[k]) begin
        newAll[status.statusIndex[k*INDEX_WIDTH +: INDEX_WIDTH]] = 1'b1;
        if (status.statusEnabled[k]) newEn[status.statusIndex[k*INDEX_WIDTH +: INDEX_WIDTH]] = 1'b1;
        winner[status.statusIndex[k*INDEX_WIDTH +: INDEX_WIDTH]] = LINK_W'(k);
      end
    end
    freshAll = newAll & ~fmpsBitmapAll;
    freshEn = newEn & ~fmpsBitmapEnabled;
    for (int i = 0; i < NODES; i++) begin
      addAll = addAll + {{INDEX_WIDTH{1'b0}}, freshAll[i]};
      addEn = addEn + {{INDEX_WIDTH{1'b0}}, freshEn[i]};
    end
  end
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      readoutActive <= 1'b0;
      readoutValid <= 1'b0;
      readTimeout <= 1'b0;
      timeoutStrobe <= 1'b0;
      fmpsEnabled <= 1'b0;
      fmpsBitmapAll <= '0;
      fmpsBitmapEnabled <= '0;
      bitmapAllSnapshot <= '0;
      bitmapEnabledSnapshot <= '0;
      readoutTime <= '0;
      seqno <= '0;
      readoutPresent <= 1'b0;
      readoutLink <= '0;
      inhibitLatched <= '0;
      allCount <= '0;
      enCount <= '0;
      timer <= '0;
      divider <= '0;
      for (int i = 0; i < NODES; i++) sourceTable[i] <= '0;
    end else begin
      timeoutStrobe <= 1'b0;
      readoutPresent <= readoutValid && fmpsBitmapAll[readoutAddress];
      readoutLink <= sourceTable[readoutAddress];
      if (FAstrobe) begin
        bitmapAllSnapshot <= fmpsBitmapAll;
        bitmapEnabledSnapshot <= fmpsBitmapEnabled;
        fmpsBitmapAll <= '0;
        fmpsBitmapEnabled <= '0;
        allCount <= '0;
        enCount <= '0;
        inhibitLatched <= linkInhibit;
        readoutActive <= 1'b1;
        readoutValid <= 1'b0;
        readTimeout <= 1'b0;
        timer <= '0;
        divider <= HALF_LOAD;
      end else if (readoutActive) begin
        fmpsBitmapAll <= fmpsBitmapAll | newAll;
        fmpsBitmapEnabled <= fmpsBitmapEnabled | newEn;
        allCount <= allCount + addAll;
        enCount <= enCount + addEn;
        for (int i = 0; i < NODES; i++) if (freshAll[i]) sourceTable[i] <= winner[i];
        if (allCount == fmpsCount) begin
          readoutValid <= 1'b1;
          fmpsEnabled <= enCount == fmpsCount;
          seqno <= seqno + SEQNO_WIDTH'(1);
          readoutTime <= timer;
          readoutActive <= 1'b0;
        end else if (divider == '0) begin
          divider <= FULL_LOAD;
          if (&timer) begin
            readTimeout <= 1'b1;
            fmpsEnabled <= 1'b0;
            timeoutStrobe <= 1'b1;
            readoutTime <= '1;
            readoutActive <= 1'b0;
          end else begin
            timer <= timer + READOUT_TIMER_WIDTH'(1);
          end
        end else begin
          divider <= divider - 32'd1;
        end
      end
    end
  end
  // Error counters run regardless of readout state or inhibit; clear beats increment.
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) linkErrorCount <= '0;
    else
      for (int k = 0; k < NUM_LINKS; k++)
        if (errorCountClear) linkErrorCount[16*k +: 16] <= '0;
        else if (status.statusValid[k] && status.statusCode[2*k +: 2] != 2'd0 &&
                 linkErrorCount[16*k +: 16] != 16'hFFFF)
          linkErrorCount[16*k +: 16] <= linkErrorCount[16*k +: 16] + 16'd1;
  end
endmodule

// File: doc/fmps_read_links_multi.md
Name: fmps_read_links_multi

Overview:
- Generalised single-clock successor to the two-link Fast MPS readout tracker.
- Accepts per-node status events from NUM_LINKS FMPS link receivers, already in the sysClk domain, and processes every link's event each cycle without an arbitration mux.
- Tracks which nodes delivered data and which are enabled, declares the readout complete or timed out per FA cycle, and reports which link first supplied each node.
- Sits between the per-link FMPS receivers and the Mitigation Node / MicroBlaze readout.

Parameters:
NUM_LINKS, 2, number of FMPS link receivers (1..8)
INDEX_WIDTH, 5, node index width; 1<<INDEX_WIDTH nodes
SYSCLK_RATE, 100000000, sysClk frequency in Hz; must be an integer multiple of 2 MHz
READOUT_TIMER_WIDTH, 5, width of the microsecond readout timer
SEQNO_WIDTH, 3, width of the completed-readout sequence number
LINK_W (derived), max(1,$clog2(NUM_LINKS)), width of a link identifier

Ports:
sysClk  in  1  system clock
sysResetN  in  1  asynchronous reset, active low
FAstrobe  in  1  start of FA cycle, single-cycle pulse
fmpsCount  in  INDEX_WIDTH+1  expected node count
linkInhibit  in  NUM_LINKS  per-link ignore mask, sampled only on FAstrobe
statusValid  in  NUM_LINKS  per-link status event strobe
statusCode  in  2*NUM_LINKS  per-link code; 0 = success
statusEnabled  in  NUM_LINKS  node-enabled flag carried with the event
statusIndex  in  NUM_LINKS*INDEX_WIDTH  node index of the event
errorCountClear  in  1  clears all link error counters
readoutActive  out  1  collection in progress
readoutValid  out  1  all expected nodes received this cycle
readTimeout  out  1  readout ended by timeout
timeoutStrobe  out  1  one-cycle pulse on timeout
fmpsEnabled  out  1  all expected nodes were enabled
fmpsBitmapAll  out  1<<INDEX_WIDTH  nodes received
fmpsBitmapEnabled  out  1<<INDEX_WIDTH  enabled nodes received
bitmapAllSnapshot  out  1<<INDEX_WIDTH  fmpsBitmapAll captured at FAstrobe
bitmapEnabledSnapshot  out  1<<INDEX_WIDTH  fmpsBitmapEnabled captured at FAstrobe
readoutTime  out  READOUT_TIMER_WIDTH  timer value when readout ended
seqno  out  SEQNO_WIDTH  completed-readout count, wraps
linkErrorCount  out  16*NUM_LINKS  per-link count of non-success events, saturating
readoutAddress  in  INDEX_WIDTH  node lookup address
readoutPresent  out  1  node at readoutAddress delivered, readout valid
readoutLink  out  LINK_W  link that first delivered the node

Behaviour:
- Reset: every register and output is 0, including the source table and the latched inhibit mask.
- Accepted event, per link k: statusValid[k] && code==0 && !inhibitLatched[k] && readoutActive && !FAstrobe.
- All accepted events in one cycle are merged:
  - newAll = OR of the one-hot indices; newEn = the same, restricted to events with statusEnabled set.
  - fmpsBitmapAll |= newAll; fmpsBitmapEnabled |= newEn.
  - The counters add popcount(newAll & ~fmpsBitmapAll) and popcount(newEn & ~fmpsBitmapEnabled). A duplicate index within one cycle, or across cycles, counts once.
  - sourceTable[i] is written only when bit i is newly set; on a tie the lowest link index wins.
- FAstrobe:
  - Copy the bitmaps to the snapshots, then clear the bitmaps and both counters.
  - Latch linkInhibit; set readoutActive=1; clear readoutValid, readTimeout and the timer.
  - Load the divider with SYSCLK_RATE/2e6-1, so the first tick comes after half a microsecond.
  - FAstrobe while already active restarts collection; seqno is unchanged.
- While active, each cycle, using registered counter values:
  - If counter==fmpsCount: readoutValid<=1, fmpsEnabled<=(enCounter==fmpsCount), seqno++, readoutTime<=timer, readoutActive<=0.
  - Else, if a divider tick occurs with timer all ones: readTimeout<=1, fmpsEnabled<=0, timeoutStrobe pulses for 1 cycle, readoutTime<=all ones, readoutActive<=0.
  - Completion has priority over timeout in the same cycle.
  - A tick with the timer not all ones increments the timer; the divider then reloads SYSCLK_RATE/1e6-1.
- fmpsCount==0: completion occurs one cycle after FAstrobe.
- Events outside readoutActive are ignored by the bitmaps.
- linkErrorCount:
  - Counts every statusValid with code!=0, regardless of active state or inhibit.
  - Saturates at 0xFFFF.
  - errorCountClear has priority over a simultaneous increment.
- Lookup: 1-cycle latency. readoutPresent <= readoutValid && fmpsBitmapAll[readoutAddress]; readoutLink <= sourceTable[readoutAddress].
- sysResetN deassertion mid-operation leaves the block idle until the next FAstrobe.

Test Plan:
- NUM_LINKS=2, fmpsCount=3, success events idx 0,1,2 on link0 -> readoutValid=1 one cycle after the third event; seqno=1; readoutLink=0 for each node.
- Links 0 and 1 both report idx 5 in the same cycle, fmpsCount=1 -> counter=1, not 2; readoutLink(5)=0; readoutValid asserted.
- fmpsCount=4, only 3 nodes arrive, SYSCLK_RATE=100 MHz -> readTimeout=1 and timeoutStrobe pulses 31.5 µs after FAstrobe; readoutTime=31; fmpsEnabled=0; seqno unchanged.
- linkInhibit=01 at FAstrobe, events on both links -> link0 events ignored; link1 alone completes readout; readoutLink=1.
- 0x10000 errors on link1, then errorCountClear concurrent with an error -> count holds at 0xFFFF, then reads 0.
- sysResetN asserted mid-readout -> all outputs 0 immediately; next FAstrobe runs a full readout normally.
